rect_fill_writer: RTL and testbench
===================================

Name: rect_fill_writer

Overview:
- Write-side companion to the 320x240, 3-bit-per-pixel image store.
- Accepts one rectangle command (origin, size, colour) through a valid/ready handshake.
- Emits a raster-order stream of pixel writes (x, y, data, strobe) into the frame buffer RAM port, with clipping to screen bounds.
- Used by game logic to draw and erase the Simon pad highlights and backgrounds.

Parameters:
- H_RES, 320, screen width in pixels; x must be < H_RES.
- V_RES, 240, screen height in pixels; y must be < V_RES.
- XW, 9, x coordinate and width bit width.
- YW, 8, y coordinate and height bit width.
- CW, 3, pixel colour width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  XW  rectangle left column.
- cmd_y  in  YW  rectangle top row.
- cmd_w  in  XW  width in pixels.
- cmd_h  in  YW  height in pixels.
- cmd_color  in  CW  fill colour.
- wr_ready  in  1  frame buffer accepts a write this cycle.
- wr_en  out  1  pixel write strobe.
- wr_x  out  XW  write column.
- wr_y  out  YW  write row.
- wr_data  out  CW  write colour.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset: the engine returns to IDLE on the rising edge with rst_n=0. In IDLE, cmd_ready=1, wr_en=0, wr_x=0, wr_y=0, wr_data=0, busy=0, done=0. Reset in the middle of a command abandons it with no done pulse.
- States:
  - IDLE: cmd_ready=1. When cmd_valid and cmd_ready are both high at an edge, the engine latches the command. It goes to DRAW, or to FINISH if the clipped rectangle is empty.
  - DRAW: one pixel is presented per cycle. Each cycle, wr_en=1 and wr_x/wr_y/wr_data are valid. A write is consumed on an edge where wr_en and wr_ready are both high. While wr_ready=0, all write outputs hold their values.
  - FINISH: done=1 for exactly one cycle, then the engine returns to IDLE.
- Clipping:
  - Compute x_end = min(cmd_x + cmd_w, H_RES) and y_end = min(cmd_y + cmd_h, V_RES). The sums use XW+1 and YW+1 bits, with no wrap.
  - The rectangle is empty if cmd_w==0, cmd_h==0, cmd_x>=H_RES, or cmd_y>=V_RES.
  - An empty rectangle produces zero writes and goes directly to FINISH.
- Order: row-major scan.
  - The first pixel is (cmd_x, cmd_y).
  - wr_x increments until x_end-1, then wraps to cmd_x while wr_y increments.
  - The last pixel is (x_end-1, y_end-1). After it is consumed, the engine goes to FINISH.
- Latency:
  - With the handshake at edge N, the first wr_en is high in cycle N+1.
  - With wr_ready held high, an unclipped WxH rectangle completes in W*H consecutive write cycles.
  - done is high in the cycle after the last consumed write.
  - For an empty rectangle, done is high in cycle N+1.
- Handshake:
  - cmd_ready=0 throughout DRAW and FINISH. Commands presented then are not accepted and must be held by the source.
  - The earliest next accept is the first IDLE cycle after done.
- busy=1 in DRAW and FINISH.
- wr_data holds the latched colour for the whole command.

Optional Feature:
- RECT_OUTLINE_EN defined:
  - Adds an input port cmd_outline (1 bit), latched with the command.
  - When cmd_outline=1, wr_en is asserted only on border pixels of the clipped rectangle: the first or last row, or the first or last column.
  - Interior positions are still scanned, one per cycle, with wr_en=0. They do not wait on wr_ready.
  - Total cycle count for a command is (pixels written, stall-dependent) + (interior pixels).
  - When cmd_outline=0, behaviour is a normal fill.
- RECT_OUTLINE_EN not defined: the port is absent and every command is a full fill.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release → cmd_ready=1, wr_en=0, busy=0, done=0, wr_x=0, wr_y=0.
- Basic fill: x=10, y=20, w=3, h=2, color=5, wr_ready=1 → 6 writes in order (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all with data=5. done occurs on the 7th cycle after accept, and cmd_ready returns the following cycle.
- Backpressure: same command, with wr_ready toggled 1,0,0,1,... → each pixel is held stable while wr_ready=0. Exactly 6 consumed writes, no duplicates or skips.
- Clipping: x=318, y=238, w=5, h=5, color=2 → writes only (318,238), (319,238), (318,239), (319,239), then done.
- Empty commands: w=0, then x=320, then y=240 → zero wr_en cycles in each case. done occurs one cycle after accept.
- Reset mid-draw and outline:
  - Reset mid-draw: assert rst_n=0 after 3 writes of a 4x4 fill → IDLE next edge, no done pulse, and a new command is accepted afterwards.
  - Outline (with RECT_OUTLINE_EN): x=0, y=0, w=4, h=4, outline=1 → 12 writes; (1,1), (2,1), (1,2) and (2,2) are skipped.

Source files
------------

// File: rtl/rect_fill_writer.sv
// rect_fill_writer: accepts one rectangle command (origin, size, colour) and
// streams raster-order pixel writes into the 320x240 frame buffer port,
// clipping the rectangle against the screen edges.
// Optional build macro: RECT_OUTLINE_EN adds cmd_outline, which limits writes
// to the border pixels of the clipped rectangle.
module rect_fill_writer #(
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic [CW-1:0] cmd_color,
`ifdef RECT_OUTLINE_EN
  input  logic          cmd_outline,
`endif
  input  logic          wr_ready,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [CW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FINISH
  } state_t;

  localparam logic [XW:0]   H_LIM  = H_RES;
  localparam logic [YW:0]   V_LIM  = V_RES;
  localparam logic [XW-1:0] H_LAST = H_RES - 1;
  localparam logic [YW-1:0] V_LAST = V_RES - 1;
  localparam logic [XW-1:0] X_ONE  = 1;
  localparam logic [YW-1:0] Y_ONE  = 1;

  state_t        state;
  logic [XW-1:0] x0;
  logic [XW-1:0] last_x;
  logic [YW-1:0] last_y;
`ifdef RECT_OUTLINE_EN
  logic [YW-1:0] y0;
  logic          outline_q;
`endif

  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;
  logic [XW-1:0] cmd_last_x;
  logic [YW-1:0] cmd_last_y;
  logic          cmd_empty;

  logic          at_row_end;
  logic          is_last;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          next_en;
  logic          advance;

  // Clip the incoming command: the sums are one bit wider so they never wrap,
  // and the inclusive last column/row is stored rather than the exclusive end.
  always_comb begin
    x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
    y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};
    if (x_sum > H_LIM) cmd_last_x = H_LAST;
    else               cmd_last_x = x_sum[XW-1:0] - X_ONE;
    if (y_sum > V_LIM) cmd_last_y = V_LAST;
    else               cmd_last_y = y_sum[YW-1:0] - Y_ONE;
    cmd_empty = (cmd_w == '0) || (cmd_h == '0) ||
                ({1'b0, cmd_x} >= H_LIM) || ({1'b0, cmd_y} >= V_LIM);
  end

  // Raster walker: next scan position, whether it is written, and whether the
  // current position is finished this cycle (interior outline cells never stall).
  always_comb begin
    at_row_end = (wr_x == last_x);
    is_last    = at_row_end && (wr_y == last_y);
    next_x     = at_row_end ? x0 : wr_x + X_ONE;
    next_y     = at_row_end ? wr_y + Y_ONE : wr_y;
    next_en    = 1'b1;
    advance    = wr_en && wr_ready;
`ifdef RECT_OUTLINE_EN
    if (outline_q) begin
      next_en = (next_x == x0) || (next_x == last_x) ||
                (next_y == y0) || (next_y == last_y);
      if (!wr_en) advance = 1'b1;
    end
`endif
  end

  // Command FSM with registered handshake, write port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      wr_en     <= 1'b0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x0        <= '0;
      last_x    <= '0;
      last_y    <= '0;
`ifdef RECT_OUTLINE_EN
      y0        <= '0;
      outline_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            x0        <= cmd_x;
            last_x    <= cmd_last_x;
            last_y    <= cmd_last_y;
            wr_data   <= cmd_color;
`ifdef RECT_OUTLINE_EN
            y0        <= cmd_y;
            outline_q <= cmd_outline;
`endif
            if (cmd_empty) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= DRAW;
              wr_en <= 1'b1;
              wr_x  <= cmd_x;
              wr_y  <= cmd_y;
            end
          end
        end
        DRAW: begin
          if (advance) begin
            if (is_last) begin
              state <= FINISH;
              wr_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              wr_x  <= next_x;
              wr_y  <= next_y;
              wr_en <= next_en;
            end
          end
        end
        FINISH: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          wr_en     <= 1'b0;
          wr_x      <= '0;
          wr_y      <= '0;
          wr_data   <= '0;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          wr_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_writer.sv
// tb_rect_fill_writer: directed and randomized rectangle commands for
// rect_fill_writer, compared against a rectangle/clipping model built with
// plain nested loops over the expected pixel set.
module tb_rect_fill_writer;

  localparam int H_RES = 320;
  localparam int V_RES = 240;
  localparam int XW    = 9;
  localparam int YW    = 8;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmdValid;
  logic          cmdReady;
  logic [XW-1:0] cmdX;
  logic [YW-1:0] cmdY;
  logic [XW-1:0] cmdW;
  logic [YW-1:0] cmdH;
  logic [CW-1:0] cmdColor;
  logic          cmdOutline;
  logic          wrReady;
  logic          wrEn;
  logic [XW-1:0] wrX;
  logic [YW-1:0] wrY;
  logic [CW-1:0] wrData;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  int expX[$];
  int expY[$];
  int expArea;

  // Free-running clock
  always #5 clk = ~clk;

  rect_fill_writer #(
    .H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW), .CW(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmdValid),
    .cmd_ready  (cmdReady),
    .cmd_x      (cmdX),
    .cmd_y      (cmdY),
    .cmd_w      (cmdW),
    .cmd_h      (cmdH),
    .cmd_color  (cmdColor),
`ifdef RECT_OUTLINE_EN
    .cmd_outline(cmdOutline),
`endif
    .wr_ready   (wrReady),
    .wr_en      (wrEn),
    .wr_x       (wrX),
    .wr_y       (wrY),
    .wr_data    (wrData),
    .busy       (busy),
    .done       (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pixel list: every in-screen pixel of the rectangle in row-major
  // order; in outline mode only those on the clipped rectangle's border.
  task automatic buildModel(input int x, input int y, input int w, input int h, input bit outline);
    int xe, ye;
    expX.delete();
    expY.delete();
    expArea = 0;
    if (w == 0 || h == 0 || x >= H_RES || y >= V_RES) return;
    xe = (x + w > H_RES) ? H_RES : x + w;
    ye = (y + h > V_RES) ? V_RES : y + h;
    for (int yy = y; yy < ye; yy++) begin
      for (int xx = x; xx < xe; xx++) begin
        expArea++;
        if (!outline || xx == x || xx == xe - 1 || yy == y || yy == ye - 1) begin
          expX.push_back(xx);
          expY.push_back(yy);
        end
      end
    end
  endtask

  // Issue one command and follow it to completion. Called and returns at a
  // negedge. mode: 0 = wr_ready always 1, 1 = pattern 1,0,0, 2 = random.
  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input int color, input bit outline, input int mode);
    int          budget;
    int          cyc;
    bit          finished;
    bit          stalled;
    logic        rdy;
    logic [19:0] prevPix;
    logic [19:0] expPix;
    buildModel(x, y, w, h, outline);
    budget     = expArea * 20 + 20;
    cmdX       = XW'(x);
    cmdY       = YW'(y);
    cmdW       = XW'(w);
    cmdH       = YW'(h);
    cmdColor   = CW'(color);
    cmdOutline = outline;
    cmdValid   = 1'b1;
    wrReady    = 1'b1;
    checkOutput("accept_ready", {31'd0, cmdReady}, 32'd1);
    @(negedge clk);
    cmdValid = 1'b0;
    finished = 1'b0;
    stalled  = 1'b0;
    prevPix  = '0;
    for (cyc = 1; cyc <= budget; cyc++) begin
      if (stalled) begin
        checkOutput("hold_en", {31'd0, wrEn}, 32'd1);
        checkOutput("hold_pixel", {12'd0, wrX, wrY, wrData}, {12'd0, prevPix});
      end
      if (done) begin
        if (mode == 0) checkOutput("done_latency", cyc, expArea + 1);
        checkOutput("writes_left", expX.size(), 0);
        checkOutput("done_no_wr", {31'd0, wrEn}, 32'd0);
        finished = 1'b1;
        break;
      end
      checkOutput("busy_draw", {31'd0, busy}, 32'd1);
      checkOutput("ready_low", {31'd0, cmdReady}, 32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 1) % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      wrReady = rdy;
      if (wrEn && rdy) begin
        if (expX.size() == 0) begin
          checkOutput("extra_write", {31'd0, wrEn}, 32'd0);
        end else begin
          expPix = {XW'(expX[0]), YW'(expY[0]), CW'(color)};
          checkOutput("pixel", {12'd0, wrX, wrY, wrData}, {12'd0, expPix});
          void'(expX.pop_front());
          void'(expY.pop_front());
        end
      end
      stalled = wrEn && !rdy;
      prevPix = {wrX, wrY, wrData};
      @(negedge clk);
    end
    if (!finished) checkOutput("timeout_done", {31'd0, done}, 32'd1);
    wrReady = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_done", {31'd0, done}, 32'd0);
  endtask

  // Directed scenarios followed by randomized commands
  initial begin
    int consumed;
    int rx, ry, rw, rh;
    bit ro;
    rst_n      = 1'b0;
    cmdValid   = 1'b0;
    cmdX       = '0;
    cmdY       = '0;
    cmdW       = '0;
    cmdH       = '0;
    cmdColor   = '0;
    cmdOutline = 1'b0;
    wrReady    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("rst_wr_en", {31'd0, wrEn}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_wr_x", {23'd0, wrX}, 32'd0);
    checkOutput("rst_wr_y", {24'd0, wrY}, 32'd0);

    $display("[TB] basic fill, backpressure, clipping");
    applyStimulus(10, 20, 3, 2, 5, 1'b0, 0);
    applyStimulus(10, 20, 3, 2, 5, 1'b0, 1);
    applyStimulus(318, 238, 5, 5, 2, 1'b0, 0);

    $display("[TB] empty commands");
    applyStimulus(10, 20, 0, 4, 1, 1'b0, 0);
    applyStimulus(320, 20, 4, 4, 1, 1'b0, 0);
    applyStimulus(10, 240, 4, 4, 1, 1'b0, 0);

    $display("[TB] reset mid-draw");
    buildModel(50, 60, 4, 4, 1'b0);
    cmdX = 9'd50; cmdY = 8'd60; cmdW = 9'd4; cmdH = 8'd4; cmdColor = 3'd3;
    cmdOutline = 1'b0;
    cmdValid = 1'b1;
    wrReady  = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    consumed = 0;
    for (int i = 0; i < 20 && consumed < 3; i++) begin
      if (wrEn) consumed++;
      @(negedge clk);
    end
    checkOutput("mid_consumed", consumed, 3);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_wr_en", {31'd0, wrEn}, 32'd0);
    checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_post_done", {31'd0, done}, 32'd0);
    applyStimulus(7, 9, 2, 3, 6, 1'b0, 0);

`ifdef RECT_OUTLINE_EN
    $display("[TB] outline");
    applyStimulus(0, 0, 4, 4, 7, 1'b1, 0);
    applyStimulus(316, 5, 8, 5, 4, 1'b1, 2);
`endif

    $display("[TB] randomized commands");
    for (int n = 0; n < 20; n++) begin
      rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 100));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(225, 250)) : int'($urandom_range(0, 100));
      rw = int'($urandom_range(0, 12));
      rh = int'($urandom_range(0, 12));
      ro = 1'b0;
`ifdef RECT_OUTLINE_EN
      ro = 1'($urandom_range(0, 1));
`endif
      applyStimulus(rx, ry, rw, rh, int'($urandom_range(0, 7)), ro, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
